// File: rtl/snn_frame_sequencer_if.sv
// Bundles the descriptor, packet stream, grid and result signals of snn_frame_sequencer.
// The master modport is the sequencer side; the slave modport is the surrounding system.
interface snn_frame_sequencer_if #(
    parameter int PACKET_W   = 30,
    parameter int NUM_OUTPUT = 250,
    parameter int OUT_IDX_W  = 8,
    parameter int CNT_W      = 12,
    parameter int IDX_W      = 16
);
    logic                  frame_valid;
    logic                  frame_ready;
    logic [CNT_W-1:0]      frame_num_pkts;
    logic [NUM_OUTPUT-1:0] frame_expected;
    logic                  pkt_in_valid;
    logic                  pkt_in_ready;
    logic [PACKET_W-1:0]   pkt_in_data;
    logic [PACKET_W-1:0]   grid_packet_in;
    logic                  grid_input_buffer_empty;
    logic                  grid_ren;
    logic                  grid_tick;
    logic [OUT_IDX_W-1:0]  grid_packet_out;
    logic                  grid_packet_out_valid;
    logic                  grid_done;
    logic                  res_valid;
    logic                  res_ready;
    logic [IDX_W-1:0]      res_frame_idx;
    logic [NUM_OUTPUT-1:0] res_spikes;
    logic [15:0]           res_spike_cnt;
    logic                  res_match;
    logic                  res_timeout;
    logic                  err_range;
    logic                  err_stray;

    modport master (
        input  frame_valid, frame_num_pkts, frame_expected,
        input  pkt_in_valid, pkt_in_data,
        input  grid_ren, grid_packet_out, grid_packet_out_valid, grid_done,
        input  res_ready,
        output frame_ready, pkt_in_ready, grid_packet_in, grid_input_buffer_empty, grid_tick,
        output res_valid, res_frame_idx, res_spikes, res_spike_cnt, res_match, res_timeout,
        output err_range, err_stray
    );

    modport slave (
        output frame_valid, frame_num_pkts, frame_expected,
        output pkt_in_valid, pkt_in_data,
        output grid_ren, grid_packet_out, grid_packet_out_valid, grid_done,
        output res_ready,
        input  frame_ready, pkt_in_ready, grid_packet_in, grid_input_buffer_empty, grid_tick,
        input  res_valid, res_frame_idx, res_spikes, res_spike_cnt, res_match, res_timeout,
        input  err_range, err_stray
    );
endinterface

// File: rtl/snn_frame_sequencer.sv
// Per-frame feed / tick / collect sequencer for a RANC neuron-core grid.
// Optional macro GOLDEN_CMP_EN adds the expected-bitmap register and comparator behind res_match.
module snn_frame_sequencer #(
    parameter int PACKET_W        = 30,
    parameter int NUM_OUTPUT      = 250,
    parameter int OUT_IDX_W       = 8,
    parameter int CNT_W           = 12,
    parameter int IDX_W           = 16,
    parameter int TICK_GAP        = 30,
    parameter int COLLECT_TIMEOUT = 70000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    snn_frame_sequencer_if.master bus
);
    localparam int GAP_W = (TICK_GAP > 1) ? $clog2(TICK_GAP) : 1;
    localparam int TMO_W = (COLLECT_TIMEOUT > 1) ? $clog2(COLLECT_TIMEOUT) : 1;
    localparam int BIT_W = (NUM_OUTPUT > 1) ? $clog2(NUM_OUTPUT) : 1;
    localparam logic [GAP_W-1:0]      GAP_LAST = GAP_W'((TICK_GAP > 0) ? TICK_GAP - 1 : 0);
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'((COLLECT_TIMEOUT > 0) ? COLLECT_TIMEOUT - 1 : 0);
    localparam logic [NUM_OUTPUT-1:0] BIT_ONE  = NUM_OUTPUT'(1'b1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FEED    = 3'd1,
        S_GAP     = 3'd2,
        S_TICK    = 3'd3,
        S_COLLECT = 3'd4,
        S_REPORT  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      remaining_q, remaining_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [NUM_OUTPUT-1:0] bitmap_q, bitmap_d;
    logic [15:0]           spike_cnt_q, spike_cnt_d;
    logic [IDX_W-1:0]      frame_idx_q, frame_idx_d;
    logic                  timeout_q, timeout_d;
    logic                  err_range_q, err_range_d;
    logic                  err_stray_q, err_stray_d;
    logic                  frame_ready_q, frame_ready_d;
    logic                  tick_q, tick_d;
    logic                  res_valid_q, res_valid_d;

    logic                  spike_in_range_s;
    logic [BIT_W-1:0]      spike_pos_s;
    logic [NUM_OUTPUT-1:0] spike_mask_s;
    logic                  capture_win_s;
    logic                  pop_s;
    logic                  go_gap_s;

    // The packet path is a pure pass-through; the grid sees "not empty" only while we still owe packets.
    assign bus.grid_packet_in          = bus.pkt_in_data;
    assign bus.pkt_in_ready            = (state_q == S_FEED) && bus.grid_ren && (|remaining_q);
    assign bus.grid_input_buffer_empty = !((state_q == S_FEED) && (|remaining_q) && bus.pkt_in_valid);
    assign pop_s                       = bus.pkt_in_ready && bus.pkt_in_valid;

    // Class idx maps to bit NUM_OUTPUT-1-idx, so class 0 lands in the bitmap MSB.
    assign spike_in_range_s = 32'(bus.grid_packet_out) < 32'(NUM_OUTPUT);
    assign spike_pos_s      = BIT_W'(NUM_OUTPUT - 1) - BIT_W'(bus.grid_packet_out);
    assign spike_mask_s     = BIT_ONE << spike_pos_s;
    assign capture_win_s    = (state_q == S_TICK) || (state_q == S_COLLECT);

    // Next-state, counters, spike capture and registered-output decode.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        gap_cnt_d   = gap_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        bitmap_d    = bitmap_q;
        spike_cnt_d = spike_cnt_q;
        frame_idx_d = frame_idx_q;
        timeout_d   = timeout_q;
        err_range_d = err_range_q;
        err_stray_d = err_stray_q;
        go_gap_s    = 1'b0;

        if (bus.grid_packet_out_valid) begin
            if (!capture_win_s) begin
                err_stray_d = 1'b1;
            end else if (!spike_in_range_s) begin
                err_range_d = 1'b1;
            end else if (!(|(bitmap_q & spike_mask_s))) begin
                bitmap_d    = bitmap_q | spike_mask_s;
                spike_cnt_d = spike_cnt_q + 16'd1;
            end else begin
                bitmap_d = bitmap_q;
            end
        end else begin
            bitmap_d = bitmap_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.frame_valid && frame_ready_q) begin
                    remaining_d = bus.frame_num_pkts;
                    if (bus.frame_num_pkts == {CNT_W{1'b0}}) go_gap_s = 1'b1;
                    else                                    state_d  = S_FEED;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FEED: begin
                if (pop_s) begin
                    remaining_d = remaining_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    if (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1}) go_gap_s = 1'b1;
                    else                                          go_gap_s = 1'b0;
                end else begin
                    remaining_d = remaining_q;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d   = S_TICK;
                else                       gap_cnt_d = gap_cnt_q + {{(GAP_W-1){1'b0}}, 1'b1};
            end
            S_TICK: begin
                state_d   = S_COLLECT;
                tmo_cnt_d = {TMO_W{1'b0}};
                timeout_d = 1'b0;
            end
            S_COLLECT: begin
                // grid_done wins over a timeout that expires in the same cycle.
                if (bus.grid_done) begin
                    state_d = S_REPORT;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = S_REPORT;
                    timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
                end
            end
            S_REPORT: begin
                if (bus.res_ready) begin
                    state_d     = S_IDLE;
                    frame_idx_d = frame_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = S_REPORT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (go_gap_s) begin
            gap_cnt_d = {GAP_W{1'b0}};
            if (TICK_GAP == 0) state_d = S_TICK;
            else               state_d = S_GAP;
        end else begin
            gap_cnt_d = gap_cnt_d;
        end

        if (state_d == S_TICK) begin
            bitmap_d    = {NUM_OUTPUT{1'b0}};
            spike_cnt_d = 16'd0;
        end else begin
            spike_cnt_d = spike_cnt_d;
        end

        frame_ready_d = (state_d == S_IDLE);
        tick_d        = (state_d == S_TICK);
        res_valid_d   = (state_d == S_REPORT);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            remaining_q   <= {CNT_W{1'b0}};
            gap_cnt_q     <= {GAP_W{1'b0}};
            tmo_cnt_q     <= {TMO_W{1'b0}};
            bitmap_q      <= {NUM_OUTPUT{1'b0}};
            spike_cnt_q   <= 16'd0;
            frame_idx_q   <= {IDX_W{1'b0}};
            timeout_q     <= 1'b0;
            err_range_q   <= 1'b0;
            err_stray_q   <= 1'b0;
            frame_ready_q <= 1'b0;
            tick_q        <= 1'b0;
            res_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            gap_cnt_q     <= gap_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            bitmap_q      <= bitmap_d;
            spike_cnt_q   <= spike_cnt_d;
            frame_idx_q   <= frame_idx_d;
            timeout_q     <= timeout_d;
            err_range_q   <= err_range_d;
            err_stray_q   <= err_stray_d;
            frame_ready_q <= frame_ready_d;
            tick_q        <= tick_d;
            res_valid_q   <= res_valid_d;
        end
    end

    assign bus.frame_ready   = frame_ready_q;
    assign bus.grid_tick     = tick_q;
    assign bus.res_valid     = res_valid_q;
    assign bus.res_frame_idx = frame_idx_q;
    assign bus.res_spikes    = bitmap_q;
    assign bus.res_spike_cnt = spike_cnt_q;
    assign bus.res_timeout   = timeout_q;
    assign bus.err_range     = err_range_q;
    assign bus.err_stray     = err_stray_q;

`ifdef GOLDEN_CMP_EN
    logic [NUM_OUTPUT-1:0] expected_q, expected_d;
    logic                  match_q, match_d;

    // Golden bitmap latch at accept; verdict frozen as COLLECT hands over to REPORT.
    always_comb begin
        expected_d = expected_q;
        match_d    = match_q;
        if ((state_q == S_IDLE) && bus.frame_valid && frame_ready_q) expected_d = bus.frame_expected;
        else                                                         expected_d = expected_q;
        if ((state_q == S_COLLECT) && (state_d == S_REPORT)) match_d = (bitmap_d == expected_q) && !timeout_d;
        else                                                 match_d = match_q;
    end

    // Golden comparison registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            expected_q <= {NUM_OUTPUT{1'b0}};
            match_q    <= 1'b0;
        end else begin
            expected_q <= expected_d;
            match_q    <= match_d;
        end
    end

    assign bus.res_match = match_q;
`else
    logic unused_expected_s;
    assign unused_expected_s = ^bus.frame_expected;
    assign bus.res_match     = 1'b0;
`endif
endmodule
